// File: rtl/pdm_mic_decimator.sv
// pdm_mic_decimator: PDM mic clock generator and boxcar decimator producing signed 8-bit PCM samples
module pdm_mic_decimator #(
  parameter int MIC_HALF   = 16,
  parameter int DECIM_LOG2 = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       mic_data_in,
  output logic       mic_clk_out,
  output logic       mic_lrsel_out,
  output logic       ready_out,
  output logic [7:0] pcm_out,
  output logic       clip_out
);
  localparam int D  = DECIM_LOG2;
  localparam int CW = $clog2(MIC_HALF + 1);
  localparam logic [D:0] HALF = {2'b01, {(D-1){1'b0}}};
  localparam logic signed [D:0] PFS = {{(D-7){1'b0}}, 8'h80};
  logic [CW-1:0] div;
  logic [1:0] sync;
  logic [D-1:0] bcnt;
  logic [D:0] ones, total;
  logic signed [D:0] diff, scaled;
  logic clk_d, tc, cap, last, sat;
  assign mic_lrsel_out = 1'b0;
  always_comb begin
    tc     = div == CW'(MIC_HALF - 1);
    cap    = clk_d & ~mic_clk_out;
    last   = cap & (&bcnt);
    total  = ones + {{D{1'b0}}, sync[1]};
    diff   = total - HALF;
    scaled = diff >>> (D - 8);
    sat    = scaled == PFS;
  end
  // capture fires the cycle after the registered mic clock falls; clk_d is cleared on disable so stopping never fakes a fall
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div         <= '0;
      mic_clk_out <= 1'b0;
      clk_d       <= 1'b0;
      sync        <= '0;
      bcnt        <= '0;
      ones        <= '0;
      ready_out   <= 1'b0;
      pcm_out     <= '0;
      clip_out    <= 1'b0;
    end else begin
      sync      <= {sync[0], mic_data_in};
      ready_out <= last;
      if (last) begin
        pcm_out  <= sat ? 8'h7f : scaled[7:0];
        clip_out <= clip_out | sat;
      end
      if (!enable_in) begin
        div         <= '0;
        mic_clk_out <= 1'b0;
        clk_d       <= 1'b0;
      end else begin
        div         <= tc ? '0 : div + 1'b1;
        mic_clk_out <= mic_clk_out ^ tc;
        clk_d       <= mic_clk_out;
      end
      if (!enable_in || last) begin
        bcnt <= '0;
        ones <= '0;
      end else if (cap) begin
        bcnt <= bcnt + 1'b1;
        ones <= total;
      end
    end
  end
endmodule

// File: tb/tb_pdm_mic_decimator.sv
// tb_pdm_mic_decimator: directed table-driven bench for the PDM decimator at DECIM_LOG2 8 and 10
module tb_pdm_mic_decimator;
  typedef struct {
    int         mode;
    logic [7:0] pcm;
    logic       clip;
  } vec_t;
  logic clk, rst_a, rst_b, en_a, en_b, da, db;
  logic mclk_a, mclk_b, lr_a, lr_b, rdy_a, rdy_b, clip_a, clip_b;
  logic [7:0] pcm_a, pcm_b;
  logic clr_a, clr_b, pa, pb;
  int cyc, total, bad, mode_a, mode_b, idx_a, idx_b;
  vec_t tab[5];
  pdm_mic_decimator dut_a (
    .clk_in(clk), .rst_in(rst_a), .enable_in(en_a), .mic_data_in(da),
    .mic_clk_out(mclk_a), .mic_lrsel_out(lr_a), .ready_out(rdy_a),
    .pcm_out(pcm_a), .clip_out(clip_a)
  );
  pdm_mic_decimator #(.MIC_HALF(16), .DECIM_LOG2(10)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .enable_in(en_b), .mic_data_in(db),
    .mic_clk_out(mclk_b), .mic_lrsel_out(lr_b), .ready_out(rdy_b),
    .pcm_out(pcm_b), .clip_out(clip_b)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_a <= rst_a | ~en_a;
    clr_b <= rst_b | ~en_b;
  end
  // 1 = all ones, 2 = alternating (half ones), 3 = three of every four bits set, else all zeros
  function automatic logic pat(input int m, input int i);
    return m == 1 ? 1'b1 : m == 2 ? (i % 2 == 0) : m == 3 ? (i % 4 != 3) : 1'b0;
  endfunction
  // model microphone: a new bit is launched just after each mic clock rising edge
  always @(negedge clk) begin
    if (clr_a) idx_a = 0;
    else if (mclk_a && !pa) begin
      da = pat(mode_a, idx_a);
      idx_a++;
    end
    pa = mclk_a;
    if (clr_b) idx_b = 0;
    else if (mclk_b && !pb) begin
      db = pat(mode_b, idx_b);
      idx_b++;
    end
    pb = mclk_b;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_rdy(input bit b, input int lim, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b ? rdy_b : rdy_a) && n < lim);
    at = cyc;
    chk(b ? "b_ready_seen" : "a_ready_seen", int'(b ? rdy_b : rdy_a), 1);
  endtask
  task automatic run_a();
    int c0, t, n, at, prev, hi, rd;
    mode_a = tab[0].mode;
    en_a = 1;
    c0 = cyc;
    n = 0;
    while (!mclk_a && n < 100) begin @(negedge clk); n++; end
    chk("mclk_first_rise", cyc - c0, 16);
    t = cyc;
    while (mclk_a && n < 200) begin @(negedge clk); n++; end
    chk("mclk_high", cyc - t, 16);
    while (!mclk_a && n < 300) begin @(negedge clk); n++; end
    chk("mclk_period", cyc - t, 32);
    prev = c0;
    for (int i = 0; i < 5; i++) begin
      mode_a = tab[i].mode;
      wait_rdy(0, 9000, at);
      chk(i == 0 ? "a_first_latency" : "a_spacing", at - prev, i == 0 ? 8193 : 8192);
      chk("a_pcm", int'(pcm_a), int'(tab[i].pcm));
      chk("a_clip", int'(clip_a), int'(tab[i].clip));
      prev = at;
      @(negedge clk);
      chk("a_ready_width", int'(rdy_a), 0);
    end
    repeat (3200) @(negedge clk);
    en_a = 0;
    hi = 0;
    rd = 0;
    repeat (50) begin
      @(negedge clk);
      hi += int'(mclk_a);
      rd += int'(rdy_a);
    end
    chk("dis_mclk_high_cycles", hi, 0);
    chk("dis_ready_cycles", rd, 0);
    mode_a = 0;
    en_a = 1;
    c0 = cyc;
    wait_rdy(0, 9000, at);
    chk("reen_latency", at - c0, 8193);
    chk("reen_pcm", int'(pcm_a), 8'h80);
    chk("reen_clip_held", int'(clip_a), 1);
    mode_a = 1;
    repeat (1000) @(negedge clk);
    rst_a = 1;
    @(negedge clk);
    chk("rst_clip", int'(clip_a), 0);
    chk("rst_pcm", int'(pcm_a), 0);
    chk("rst_mclk", int'(mclk_a), 0);
    chk("rst_ready", int'(rdy_a), 0);
    rst_a = 0;
    c0 = cyc;
    wait_rdy(0, 9000, at);
    chk("post_rst_latency", at - c0, 8193);
    chk("post_rst_pcm", int'(pcm_a), 8'h7f);
    chk("post_rst_clip", int'(clip_a), 1);
  endtask
  task automatic run_b();
    int c0, at, at2;
    mode_b = 1;
    en_b = 1;
    c0 = cyc;
    wait_rdy(1, 40000, at);
    chk("b_first_latency", at - c0, 32769);
    chk("b_pcm_full", int'(pcm_b), 8'h7f);
    chk("b_clip", int'(clip_b), 1);
    mode_b = 3;
    @(negedge clk);
    chk("b_ready_width", int'(rdy_b), 0);
    wait_rdy(1, 40000, at2);
    chk("b_spacing", at2 - at, 32768);
    chk("b_pcm_768", int'(pcm_b), 8'h40);
  endtask
  initial begin
    tab[0] = '{0, 8'h80, 1'b0};
    tab[1] = '{2, 8'h00, 1'b0};
    tab[2] = '{3, 8'h40, 1'b0};
    tab[3] = '{1, 8'h7f, 1'b1};
    tab[4] = '{1, 8'h7f, 1'b1};
    total = 0;
    bad = 0;
    mode_a = 0;
    mode_b = 0;
    rst_a = 1;
    rst_b = 1;
    en_a = 0;
    en_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_state_mclk", int'(mclk_a), 0);
    chk("rst_state_ready", int'(rdy_a), 0);
    chk("rst_state_pcm", int'(pcm_a), 0);
    chk("rst_state_clip", int'(clip_a), 0);
    chk("lrsel", int'(lr_a), 0);
    chk("rst_state_b_pcm", int'(pcm_b), 0);
    rst_a = 0;
    rst_b = 0;
    fork
      run_a();
      run_b();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdm_mic_decimator.md
Name: pdm_mic_decimator

Overview:
- Microphone front end that produces the signed 8-bit PCM sample stream and one-cycle sample strobe consumed by the record/playback block.
- Generates the PDM microphone clock from the 100 MHz system clock and captures the 1-bit PDM stream.
- Decimates the stream with a boxcar ones-counter over 2^DECIM_LOG2 bits.
- Emits one PCM sample and ready strobe per window.

Parameters:
- MIC_HALF, 16: clk_in cycles per mic_clk_out half-period. Default gives 3.125 MHz.
- DECIM_LOG2, 8: log2 of PDM bits per PCM sample. Legal range 8..12. Default gives 12.207 kHz.

Ports:
- clk_in  input  1  100 MHz system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- enable_in  input  1  1 = run mic clock and decimator; 0 = idle and clear.
- mic_data_in  input  1  PDM data from the microphone; asynchronous to clk_in.
- mic_clk_out  output  1  PDM microphone clock.
- mic_lrsel_out  output  1  microphone channel select; constant 0.
- ready_out  output  1  one-cycle strobe: a new pcm_out is valid.
- pcm_out  output  8  signed PCM sample (two's complement).
- clip_out  output  1  sticky flag: an output sample was saturated.

Behaviour:
- Reset: rst_in is synchronous and active-high, single clock clk_in. It has priority over everything. On reset:
  - mic_clk_out=0, ready_out=0, pcm_out=0, clip_out=0.
  - Divider counter, bit counter, ones accumulator and synchronizer all cleared.
- mic_lrsel_out is tied to 0 at all times.
- Synchronizer: mic_data_in passes through 2 flops before use.
- Divider:
  - Counter runs 0..MIC_HALF-1 while enable_in=1.
  - On terminal count, mic_clk_out toggles and the counter returns to 0.
  - Period is 2*MIC_HALF cycles, 50% duty. First rising edge occurs MIC_HALF cycles after the first enabled cycle.
- Capture:
  - One PDM bit is taken from the synchronizer output on each clk_in cycle where mic_clk_out is registered going 1->0.
  - That bit was launched by the mic after the rising edge, MIC_HALF cycles earlier.
- Accumulate:
  - ones counter is DECIM_LOG2+1 bits wide; it adds the captured bit.
  - bit counter is DECIM_LOG2 bits wide; it increments on each capture.
- Window end (capture of bit number 2^DECIM_LOG2, i.e. bit counter = all ones):
  - total = ones + current bit.
  - Accumulators restart at 0 on the same cycle, so no bit is lost or double-counted.
- Arithmetic:
  - diff = total - 2^(DECIM_LOG2-1), signed DECIM_LOG2+1 bits.
  - scaled = diff >>> (DECIM_LOG2-8), arithmetic shift; range -128..+128.
  - If scaled = +128: pcm_out=127 and clip_out is set (sticky until rst_in). Otherwise pcm_out=scaled[7:0].
  - Negative full scale (-128) is exact and does not set clip.
- Latency:
  - pcm_out updates and ready_out pulses high for exactly 1 cycle, on the cycle after the window-end capture.
  - pcm_out holds its value between strobes.
  - Strobe spacing is exactly 2*MIC_HALF*2^DECIM_LOG2 cycles (8192 at defaults).
  - The first ready_out occurs that many cycles + 1 after the first enabled cycle.
- enable_in=0, from the next cycle:
  - mic_clk_out=0.
  - Divider, bit counter and ones counter cleared.
  - Partial window discarded; no ready_out.
  - pcm_out and clip_out hold.
  - Re-enable starts a fresh, full window.
- Simultaneous window end and enable_in falling: the sample still completes, and ready_out pulses on the next cycle.
- rst_in mid-window: no ready_out for the partial window.

Test Plan:
- Reset, then enable_in=1 with mic_data_in constant 1:
  - mic_clk_out period is 32 cycles, high 16 / low 16.
  - First ready_out occurs 8193 cycles after enable.
  - pcm_out=127 (0x7F) and clip_out=1.
  - ready_out width is 1 cycle and pulses repeat every 8192 cycles.
- mic_data_in constant 0 -> every sample pcm_out=-128 (0x80); clip_out stays 0.
- mic_data_in alternating 1,0 per mic clock (128 ones/window) -> pcm_out=0. A pattern of 192 ones per window -> pcm_out=64 (0x40).
- 100 bits of 1, then enable_in=0 for 50 cycles, then re-enable with constant 0:
  - mic_clk_out=0 during the disable; no ready during the disable.
  - First ready occurs 8193 cycles after re-enable, with pcm_out=-128.
  - Earlier ones are discarded.
- rst_in pulse mid-window after a clipped sample:
  - clip_out=0, pcm_out=0, mic_clk_out=0 on the next cycle.
  - Next ready occurs 8193 cycles after enabled operation resumes.
- DECIM_LOG2=10, constant 1 -> pcm_out=127, clip_out=1, strobe spacing 32768 cycles. With 512+256 ones per window -> diff=256, pcm_out=64.
